// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel datapath: input gating, threshold shadow, border mask.
// Optional SOBEL_CTRL_EDGE_STATS_EN adds a per-frame edge-pixel count on oEDGE_CNT.
module sobel_frame_ctrl #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter logic [7:0]  THRESH_RST = 8'd64
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iVSYNC,
  input  logic        iDVAL,
  input  logic [9:0]  iDATA,
  input  logic        iCFG_WE,
  input  logic [7:0]  iCFG_THR,
  output logic        oS_DVAL,
  output logic [9:0]  oS_DATA,
  output logic [7:0]  oTHRESHOLD,
  input  logic        iS_DVAL,
  input  logic [9:0]  iS_DATA,
  output logic        oDVAL,
  output logic [9:0]  oDATA,
  output logic        oFRAME_DONE,
  output logic        oFRAME_ERR
`ifdef SOBEL_CTRL_EDGE_STATS_EN
  ,
  output logic [18:0] oEDGE_CNT
`endif
);

  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int RW = $clog2(V_ACTIVE + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_ACTIVE
  } state_t;

  state_t        state_q, state_d;
  logic          vs_q;
  logic          sdv_q;
  logic [7:0]    pend_q, pend_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [CW-1:0] col_q, col_d, col_n;
  logic [RW-1:0] row_q, row_d, row_n;
  logic          ovf_q, ovf_d, ovf_n;
  logic          os_dval_q, os_dval_d;
  logic [9:0]    os_data_q, os_data_d;
  logic          odval_q, odval_d;
  logic [9:0]    odata_q, odata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic rise, fall, active, s_fall, border, geom_err;

  always_comb begin
    rise   = iVSYNC & ~vs_q;
    fall   = ~iVSYNC & vs_q;
    active = (state_q == S_ACTIVE);
    s_fall = ~iS_DVAL & sdv_q;
    border = (row_q < RW'(2)) | (col_q < CW'(2));

    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (rise) state_d = S_SYNC;
      S_SYNC:   if (fall) state_d = S_ACTIVE;
      S_ACTIVE: if (rise) state_d = S_SYNC;
      default:  state_d = S_IDLE;
    endcase

    // A write coinciding with a rise only reaches pending; shadow takes the old value.
    pend_d   = iCFG_WE ? iCFG_THR : pend_q;
    shadow_d = rise ? pend_q : shadow_q;

    col_n = col_q;
    row_n = row_q;
    ovf_n = ovf_q;
    if (iS_DVAL) begin
      if (col_q == CW'(H_ACTIVE)) ovf_n = 1'b1;
      else                        col_n = col_q + CW'(1);
    end
    if (s_fall) begin
      col_n = '0;
      if (row_q != RW'(V_ACTIVE + 1)) row_n = row_q + RW'(1);
    end

    geom_err = (row_n != RW'(V_ACTIVE)) | ovf_n;

    col_d = rise ? '0   : col_n;
    row_d = rise ? '0   : row_n;
    ovf_d = rise ? 1'b0 : ovf_n;

    done_d = rise & active;
    err_d  = rise & active & geom_err;

    os_dval_d = iDVAL & active;
    os_data_d = iDVAL ? iDATA : '0;

    odval_d = iS_DVAL & active;
    odata_d = '0;
    if (odval_d) odata_d = border ? 10'h3FF : iS_DATA;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      vs_q      <= 1'b0;
      sdv_q     <= 1'b0;
      pend_q    <= THRESH_RST;
      shadow_q  <= THRESH_RST;
      col_q     <= '0;
      row_q     <= '0;
      ovf_q     <= 1'b0;
      os_dval_q <= 1'b0;
      os_data_q <= '0;
      odval_q   <= 1'b0;
      odata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= iVSYNC;
      sdv_q     <= iS_DVAL;
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
      col_q     <= col_d;
      row_q     <= row_d;
      ovf_q     <= ovf_d;
      os_dval_q <= os_dval_d;
      os_data_q <= os_data_d;
      odval_q   <= odval_d;
      odata_q   <= odata_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign oS_DVAL     = os_dval_q;
  assign oS_DATA     = os_data_q;
  assign oTHRESHOLD  = shadow_q;
  assign oDVAL       = odval_q;
  assign oDATA       = odata_q;
  assign oFRAME_DONE = done_q;
  assign oFRAME_ERR  = err_q;

`ifdef SOBEL_CTRL_EDGE_STATS_EN
  logic [18:0] edge_q, edge_d, edge_n;
  logic [18:0] ecnt_q, ecnt_d;

  // The beat arriving with the rise is counted into the latched total.
  always_comb begin
    edge_n = edge_q;
    if (odval_d & ~border & (iS_DATA == 10'd0)) edge_n = edge_q + 19'd1;
    edge_d = rise ? '0 : edge_n;
    ecnt_d = (rise & active) ? edge_n : ecnt_q;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      edge_q <= '0;
      ecnt_q <= '0;
    end else begin
      edge_q <= edge_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign oEDGE_CNT = ecnt_q;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a reduced 8x6 geometry.
// Short vector table for sequencing, then whole-frame sequences.
module tb_sobel_frame_ctrl;

  localparam int H = 8;
  localparam int V = 6;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b1;
  logic       iVSYNC = 1'b0;
  logic       iDVAL = 1'b0;
  logic [9:0] iDATA = '0;
  logic       iCFG_WE = 1'b0;
  logic [7:0] iCFG_THR = '0;
  logic       iS_DVAL = 1'b0;
  logic [9:0] iS_DATA = '0;
  logic       oS_DVAL;
  logic [9:0] oS_DATA;
  logic [7:0] oTHRESHOLD;
  logic       oDVAL;
  logic [9:0] oDATA;
  logic       oFRAME_DONE;
  logic       oFRAME_ERR;
`ifdef SOBEL_CTRL_EDGE_STATS_EN
  logic [18:0] oEDGE_CNT;
`endif

  sobel_frame_ctrl #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .THRESH_RST(8'd64)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iVSYNC(iVSYNC),
    .iDVAL(iDVAL),
    .iDATA(iDATA),
    .iCFG_WE(iCFG_WE),
    .iCFG_THR(iCFG_THR),
    .oS_DVAL(oS_DVAL),
    .oS_DATA(oS_DATA),
    .oTHRESHOLD(oTHRESHOLD),
    .iS_DVAL(iS_DVAL),
    .iS_DATA(iS_DATA),
    .oDVAL(oDVAL),
    .oDATA(oDATA),
    .oFRAME_DONE(oFRAME_DONE),
    .oFRAME_ERR(oFRAME_ERR)
`ifdef SOBEL_CTRL_EDGE_STATS_EN
    ,
    .oEDGE_CNT(oEDGE_CNT)
`endif
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  typedef struct {
    logic       vs;
    logic       dv;
    logic [9:0] d;
    logic       we;
    logic [7:0] thr;
    logic       sdv;
    logic [9:0] sd;
    logic       e_sdv;
    logic [9:0] e_sd;
    logic       e_dv;
    logic [9:0] e_d;
    logic       e_done;
    logic       e_err;
    logic [7:0] e_thr;
  } vec_t;

  vec_t tbl[8];

  task automatic frame(input int nrows, input int longrow,
                       input logic exp_err, input logic rise_beat,
                       input logic [7:0] thr_in, input logic wr,
                       input logic [7:0] thr_out);
    int edges;
    int n;
    logic brd;
    edges = 0;
    iVSYNC = 1'b0; iDVAL = 1'b0; iS_DVAL = 1'b0; iCFG_WE = 1'b0;
    step();
    chk("fall_dval", oDVAL, 0);
    for (int r = 0; r < nrows; r++) begin
      n = (r == longrow) ? H + 1 : H;
      for (int c = 0; c < n; c++) begin
        iDVAL = 1'b1;
        iDATA = 10'(c + r * 16);
        iS_DVAL = 1'b1;
        iS_DATA = 10'd0;
        iCFG_WE = wr && (r == 2) && (c == 0);
        iCFG_THR = 8'd100;
        step();
        brd = (r < 2) || (c < 2);
        if (!brd) edges++;
        chk("s_dval", oS_DVAL, 1);
        chk("s_data", oS_DATA, 32'(c + r * 16));
        chk("dval", oDVAL, 1);
        chk("mask", oDATA, brd ? 1023 : 0);
        chk("thr_hold", oTHRESHOLD, thr_in);
      end
      iDVAL = 1'b0; iS_DVAL = 1'b0; iCFG_WE = 1'b0;
      step();
      chk("gap_dval", oDVAL, 0);
      chk("gap_data", oDATA, 0);
      chk("gap_s_dval", oS_DVAL, 0);
      chk("gap_s_data", oS_DATA, 0);
    end
    iVSYNC = 1'b1;
    iS_DVAL = rise_beat;
    iS_DATA = 10'd0;
    step();
    chk("done", oFRAME_DONE, 1);
    chk("err", oFRAME_ERR, exp_err);
    chk("rise_beat_dval", oDVAL, rise_beat);
    chk("rise_beat_data", oDATA, rise_beat ? 1023 : 0);
    chk("thr_new", oTHRESHOLD, thr_out);
`ifdef SOBEL_CTRL_EDGE_STATS_EN
    chk("edge_cnt", oEDGE_CNT, edges);
`endif
    iS_DVAL = 1'b0;
    step();
    chk("done_pulse", oFRAME_DONE, 0);
    chk("err_pulse", oFRAME_ERR, 0);
  endtask

  initial begin
    //            vs dv d     we thr   sdv sd   e_sdv e_sd  e_dv e_d   dn er thr
    tbl[0] = '{1'b0, 1'b1, 10'd5,    1'b1, 8'd100, 1'b1, 10'd0,
               1'b0, 10'd5,    1'b0, 10'd0,    1'b0, 1'b0, 8'd64};
    tbl[1] = '{1'b1, 1'b0, 10'd0,    1'b1, 8'd77,  1'b0, 10'd0,
               1'b0, 10'd0,    1'b0, 10'd0,    1'b0, 1'b0, 8'd100};
    tbl[2] = '{1'b1, 1'b1, 10'd9,    1'b0, 8'd0,   1'b1, 10'd0,
               1'b0, 10'd9,    1'b0, 10'd0,    1'b0, 1'b0, 8'd100};
    tbl[3] = '{1'b0, 1'b1, 10'd3,    1'b0, 8'd0,   1'b1, 10'd0,
               1'b0, 10'd3,    1'b0, 10'd0,    1'b0, 1'b0, 8'd100};
    tbl[4] = '{1'b0, 1'b1, 10'd1023, 1'b0, 8'd0,   1'b1, 10'd5,
               1'b1, 10'd1023, 1'b1, 10'd1023, 1'b0, 1'b0, 8'd100};
    tbl[5] = '{1'b0, 1'b0, 10'd7,    1'b0, 8'd0,   1'b0, 10'd0,
               1'b0, 10'd0,    1'b0, 10'd0,    1'b0, 1'b0, 8'd100};
    tbl[6] = '{1'b1, 1'b0, 10'd0,    1'b0, 8'd0,   1'b0, 10'd0,
               1'b0, 10'd0,    1'b0, 10'd0,    1'b1, 1'b1, 8'd77};
    tbl[7] = '{1'b1, 1'b0, 10'd0,    1'b0, 8'd0,   1'b0, 10'd0,
               1'b0, 10'd0,    1'b0, 10'd0,    1'b0, 1'b0, 8'd77};

    #2 iRST_N = 1'b0;
    iDVAL = 1'b1; iS_DVAL = 1'b1; iDATA = 10'd33; iS_DATA = 10'd44;
    step();
    step();
    chk("rst_s_dval", oS_DVAL, 0);
    chk("rst_s_data", oS_DATA, 0);
    chk("rst_dval", oDVAL, 0);
    chk("rst_data", oDATA, 0);
    chk("rst_done", oFRAME_DONE, 0);
    chk("rst_err", oFRAME_ERR, 0);
    chk("rst_thr", oTHRESHOLD, 64);
`ifdef SOBEL_CTRL_EDGE_STATS_EN
    chk("rst_edge", oEDGE_CNT, 0);
`endif
    iRST_N = 1'b1;

    for (int i = 0; i < 8; i++) begin
      iVSYNC = tbl[i].vs;
      iDVAL = tbl[i].dv;
      iDATA = tbl[i].d;
      iCFG_WE = tbl[i].we;
      iCFG_THR = tbl[i].thr;
      iS_DVAL = tbl[i].sdv;
      iS_DATA = tbl[i].sd;
      step();
      chk($sformatf("v%0d_s_dval", i), oS_DVAL, tbl[i].e_sdv);
      chk($sformatf("v%0d_s_data", i), oS_DATA, tbl[i].e_sd);
      chk($sformatf("v%0d_dval", i), oDVAL, tbl[i].e_dv);
      chk($sformatf("v%0d_data", i), oDATA, tbl[i].e_d);
      chk($sformatf("v%0d_done", i), oFRAME_DONE, tbl[i].e_done);
      chk($sformatf("v%0d_err", i), oFRAME_ERR, tbl[i].e_err);
      chk($sformatf("v%0d_thr", i), oTHRESHOLD, tbl[i].e_thr);
    end
    iCFG_WE = 1'b0;

    frame(V, -1, 1'b0, 1'b0, 8'd77, 1'b1, 8'd100);
    frame(V - 1, -1, 1'b1, 1'b0, 8'd100, 1'b0, 8'd100);
    frame(V, 3, 1'b1, 1'b0, 8'd100, 1'b0, 8'd100);
    frame(V, -1, 1'b0, 1'b1, 8'd100, 1'b0, 8'd100);

    iVSYNC = 1'b0; iS_DVAL = 1'b0;
    step();
    iDVAL = 1'b1; iS_DVAL = 1'b1; iS_DATA = 10'd0;
    step();
    chk("pre_rst_dval", oDVAL, 1);
    #2 iRST_N = 1'b0;
    #1;
    chk("async_rst_dval", oDVAL, 0);
    chk("async_rst_s_dval", oS_DVAL, 0);
    chk("async_rst_thr", oTHRESHOLD, 64);
    step();
    iRST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_s_dval", oS_DVAL, 0);
      chk("post_rst_dval", oDVAL, 0);
    end
    iVSYNC = 1'b1;
    step();
    chk("idle_rise_done", oFRAME_DONE, 0);
    chk("idle_rise_thr", oTHRESHOLD, 64);
    iVSYNC = 1'b0;
    step();
    chk("sync_s_dval", oS_DVAL, 0);
    step();
    chk("resume_s_dval", oS_DVAL, 1);
    chk("resume_dval", oDVAL, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
